// File: rtl/seq_serializer.sv
// Parallel-to-serial source stage: accepts a WIDTH-bit word over valid/ready and
// shifts it out LSB first on DATA, with optional idle gap cycles between words.
module seq_serializer #(
  parameter int   WIDTH      = 10,
  parameter int   GAP_CYCLES = 0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       LOAD_VALID,
  input  logic [WIDTH-1:0]           LOAD_WORD,
  output logic                       LOAD_READY,
  input  logic                       ABORT,
  output logic                       DATA,
  output logic                       DATA_VALID,
  output logic [$clog2(WIDTH)-1:0]   BIT_IDX,
  output logic                       DONE,
  output logic                       BUSY,
  output logic [1:0]                 state_dbg
);

  localparam int IW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [GW-1:0]    gap_cnt;
  logic             rst_hold;
  logic             last_bit;
  logic             handshake;

  // Handshake: a word is taken at a rising edge where LOAD_VALID && LOAD_READY,
  // unless ABORT is high in SHIFT/GAP. LOAD_READY depends on registered state only.
  always_comb begin
    last_bit   = (state == S_SHIFT) && (BIT_IDX == LAST_IDX);
    LOAD_READY = !rst_hold && ((state == S_IDLE) || ((GAP_CYCLES == 0) && last_bit));
    BUSY       = (state != S_IDLE);
    handshake  = LOAD_VALID && LOAD_READY && !(ABORT && (state != S_IDLE));
    state_dbg  = state;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      shreg      <= '0;
      gap_cnt    <= '0;
      rst_hold   <= 1'b1;
      DATA       <= IDLE_LEVEL;
      DATA_VALID <= 1'b0;
      BIT_IDX    <= '0;
      DONE       <= 1'b0;
    end else begin
      rst_hold <= 1'b0;
      DONE     <= 1'b0;
      if (ABORT && (state != S_IDLE)) begin
        state      <= S_IDLE;
        gap_cnt    <= '0;
        DATA       <= IDLE_LEVEL;
        DATA_VALID <= 1'b0;
        BIT_IDX    <= '0;
      end else if (handshake) begin
        // Bit 0 goes straight to DATA; the remainder waits in the shift register.
        state      <= S_SHIFT;
        shreg      <= LOAD_WORD >> 1;
        DATA       <= LOAD_WORD[0];
        DATA_VALID <= 1'b1;
        BIT_IDX    <= '0;
      end else begin
        case (state)
          S_SHIFT: begin
            if (BIT_IDX == LAST_IDX) begin
              state      <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
              gap_cnt    <= GAP_LOAD;
              DATA       <= IDLE_LEVEL;
              DATA_VALID <= 1'b0;
              BIT_IDX    <= '0;
            end else begin
              shreg   <= shreg >> 1;
              DATA    <= shreg[0];
              BIT_IDX <= BIT_IDX + 1'b1;
              DONE    <= ((BIT_IDX + 1'b1) == LAST_IDX);
            end
          end
          S_GAP: begin
            if (gap_cnt == '0) state <= S_IDLE;
            else               gap_cnt <= gap_cnt - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: three instances (default, GAP_CYCLES=3,
// IDLE_LEVEL=1) share one stimulus stream; each step checks the relevant instance.
module tb_seq_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       lv;
  logic       abort;
  logic [9:0] word;

  logic [2:0]      ready, data, valid, done, busy;
  logic [2:0][3:0] idx;
  logic [2:0][1:0] st;

  int n_pass  = 0;
  int n_total = 0;

  logic [9:0] w_a, w_b, w_c;

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(10), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut0 (
    .CLK(clk), .RST(rst), .LOAD_VALID(lv), .LOAD_WORD(word), .LOAD_READY(ready[0]),
    .ABORT(abort), .DATA(data[0]), .DATA_VALID(valid[0]), .BIT_IDX(idx[0]),
    .DONE(done[0]), .BUSY(busy[0]), .state_dbg(st[0])
  );

  seq_serializer #(.WIDTH(10), .GAP_CYCLES(3), .IDLE_LEVEL(1'b0)) dut1 (
    .CLK(clk), .RST(rst), .LOAD_VALID(lv), .LOAD_WORD(word), .LOAD_READY(ready[1]),
    .ABORT(abort), .DATA(data[1]), .DATA_VALID(valid[1]), .BIT_IDX(idx[1]),
    .DONE(done[1]), .BUSY(busy[1]), .state_dbg(st[1])
  );

  seq_serializer #(.WIDTH(10), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1)) dut2 (
    .CLK(clk), .RST(rst), .LOAD_VALID(lv), .LOAD_WORD(word), .LOAD_READY(ready[2]),
    .ABORT(abort), .DATA(data[2]), .DATA_VALID(valid[2]), .BIT_IDX(idx[2]),
    .DONE(done[2]), .BUSY(busy[2]), .state_dbg(st[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; lv = 1'b0; abort = 1'b0; word = '0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic chk_reset_vals(input int i, input logic lvl);
    chk($sformatf("rst_data%0d", i), data[i], lvl);
    chk($sformatf("rst_valid%0d", i), valid[i], 1'b0);
    chk($sformatf("rst_idx%0d", i), idx[i], 4'd0);
    chk($sformatf("rst_done%0d", i), done[i], 1'b0);
    chk($sformatf("rst_busy%0d", i), busy[i], 1'b0);
    chk($sformatf("rst_ready%0d", i), ready[i], 1'b0);
  endtask

  initial begin
    rst = 1'b1; lv = 1'b0; abort = 1'b0; word = '0;
    step(); step();
    chk_reset_vals(0, 1'b0);
    chk_reset_vals(1, 1'b0);
    chk_reset_vals(2, 1'b1);
    rst = 1'b0;
    step();
    chk("ready_after_rst", ready[0], 1'b1);

    // Single word, default parameters.
    w_a = 10'b0100011100;
    lv = 1'b1; word = w_a;
    step();
    lv = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t1_data%0d", k), data[0], w_a[k]);
      chk($sformatf("t1_valid%0d", k), valid[0], 1'b1);
      chk($sformatf("t1_idx%0d", k), idx[0], k);
      chk($sformatf("t1_done%0d", k), done[0], (k == 9));
      chk($sformatf("t1_ready%0d", k), ready[0], (k == 9));
      step();
    end
    chk("t1_valid_end", valid[0], 1'b0);
    chk("t1_data_end", data[0], 1'b0);
    chk("t1_busy_end", busy[0], 1'b0);

    // Back-to-back streaming with LOAD_VALID held.
    do_reset();
    w_a = 10'b1110001010;
    w_b = 10'b0101010101;
    lv = 1'b1; word = w_a;
    step();
    word = w_b;
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("t2_data%0d", k), data[0], (k < 10) ? w_a[k] : w_b[k-10]);
      chk($sformatf("t2_valid%0d", k), valid[0], 1'b1);
      chk($sformatf("t2_done%0d", k), done[0], (k == 9) || (k == 19));
      step();
      if (k == 9) lv = 1'b0;
    end
    chk("t2_valid_end", valid[0], 1'b0);

    // GAP_CYCLES=3 instance with a second word waiting.
    do_reset();
    lv = 1'b1; word = w_a;
    step();
    word = w_b;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t3_data%0d", k), data[1], w_a[k]);
      chk($sformatf("t3_done%0d", k), done[1], (k == 9));
      chk($sformatf("t3_ready%0d", k), ready[1], 1'b0);
      step();
    end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("t3_gap_data%0d", g), data[1], 1'b0);
      chk($sformatf("t3_gap_valid%0d", g), valid[1], 1'b0);
      chk($sformatf("t3_gap_ready%0d", g), ready[1], 1'b0);
      chk($sformatf("t3_gap_busy%0d", g), busy[1], 1'b1);
      step();
    end
    chk("t3_idle_ready", ready[1], 1'b1);
    chk("t3_idle_busy", busy[1], 1'b0);
    step();
    lv = 1'b0;
    chk("t3_w2_data0", data[1], w_b[0]);
    chk("t3_w2_valid0", valid[1], 1'b1);
    chk("t3_w2_idx0", idx[1], 4'd0);

    // Abort at bit index 4, then a fresh word.
    do_reset();
    w_c = 10'b1010000111;
    lv = 1'b1; word = w_c;
    step();
    lv = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("t4_idx_before", idx[0], 4'd4);
    chk("t4_data_before", data[0], w_c[4]);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_valid", valid[0], 1'b0);
    chk("t4_busy", busy[0], 1'b0);
    chk("t4_ready", ready[0], 1'b1);
    chk("t4_done", done[0], 1'b0);
    chk("t4_idx", idx[0], 4'd0);
    lv = 1'b1; word = 10'b1111111111;
    step();
    lv = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t4_ones%0d", k), data[0], 1'b1);
      chk($sformatf("t4_ones_valid%0d", k), valid[0], 1'b1);
      step();
    end
    chk("t4_after_valid", valid[0], 1'b0);

    // Reset on the last bit.
    do_reset();
    lv = 1'b1; word = w_a;
    step();
    lv = 1'b0;
    for (int k = 0; k < 9; k++) step();
    chk("t5_done_before", done[0], 1'b1);
    rst = 1'b1;
    step();
    chk_reset_vals(0, 1'b0);
    step();
    chk("t5_ready_held", ready[0], 1'b0);
    rst = 1'b0;
    step();
    chk("t5_ready_back", ready[0], 1'b1);

    // Load ignored while busy; IDLE_LEVEL=1 instance with all-zero word.
    do_reset();
    chk("t6_idle_hi", data[2], 1'b1);
    lv = 1'b1; word = 10'b0000000000;
    step();
    lv = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t6_data%0d", k), data[2], 1'b0);
      chk($sformatf("t6_valid%0d", k), valid[2], 1'b1);
      if (k == 2) begin
        lv = 1'b1; word = 10'b1111111111;
        step();
        lv = 1'b0;
      end else begin
        step();
      end
    end
    chk("t6_data_end", data[2], 1'b1);
    chk("t6_valid_end", valid[2], 1'b0);

    // ABORT in IDLE does not block a handshake.
    abort = 1'b1; lv = 1'b1; word = 10'b0000000001;
    step();
    abort = 1'b0; lv = 1'b0;
    chk("t7_idle_abort_valid", valid[0], 1'b1);
    chk("t7_idle_abort_data", data[0], 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
